// File: rtl/dso_pkg.sv
// Shared definitions for the acquisition path: capture FSM states and channel/address sizing.
package dso_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ARMED,
        POST,
        DONE
    } capt_state_t;

    localparam int CAPT_ADDR_W = 9;
    localparam int NUM_CH      = 5;

endpackage

// File: rtl/capture_ctrl_if.sv
// Command, trigger and RAM-write signals of the capture sequencer, plus its state for observation.
interface capture_ctrl_if
    import dso_pkg::*;
#(
    parameter int ADDR_W = CAPT_ADDR_W
);
    // run/stop/capture_done_clr are single-cycle request pulses; there is no ready,
    // a request is acted on in the cycle it is high or dropped if the state ignores it.
    logic              run;
    logic              stop;
    logic              smpl_en;
    logic [ADDR_W-1:0] trig_pos;
    logic [NUM_CH-1:0] trig_in;
    logic [NUM_CH-1:0] trig_en;
    logic              capture_done_clr;
    logic              armed;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    logic              capture_done;
    logic              busy;
    capt_state_t       state;

    modport slave (
        input  run, stop, smpl_en, trig_pos, trig_in, trig_en, capture_done_clr,
        output armed, we, waddr, trig_addr, capture_done, busy, state
    );

    modport master (
        output run, stop, smpl_en, trig_pos, trig_in, trig_en, capture_done_clr,
        input  armed, we, waddr, trig_addr, capture_done, busy, state
    );

endinterface

// File: rtl/capture_ctrl.sv
// One-shot acquisition sequencer: circular pre-trigger fill, armed wait for a qualified
// trigger, then a programmed number of post-trigger writes before flagging completion.
module capture_ctrl
    import dso_pkg::*;
#(
    parameter int ADDR_W = CAPT_ADDR_W
) (
    input logic            clk,
    input logic            rst_n,
    capture_ctrl_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    capt_state_t       state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] tp_q, tp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;

    logic              hit;
    logic              wr;
    logic              start;
    logic [ADDR_W:0]   cnt_inc;

    assign hit     = |(bus.trig_in & bus.trig_en);
    assign wr      = bus.smpl_en && (state_q inside {PRE, ARMED, POST});
    assign start   = bus.run && !bus.stop && (state_q inside {IDLE, DONE});
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        waddr_d     = wr ? waddr_q + 1'b1 : waddr_q;
        trig_addr_d = trig_addr_q;
        tp_d        = tp_q;
        cnt_d       = cnt_q;
        done_d      = done_q;

        case (state_q)
            PRE: begin
                if (wr) begin
                    cnt_d = cnt_inc;
                    // tp == 0 leaves DEPTH_C here, so a full ring is written before arming.
                    if (cnt_inc == DEPTH_C - {1'b0, tp_q}) state_d = ARMED;
                end
            end
            ARMED: begin
                if (hit) begin
                    trig_addr_d = waddr_q + ADDR_W'(wr);
                    cnt_d       = '0;
                    if (tp_q != '0) begin
                        state_d = POST;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            POST: begin
                if (wr) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == {1'b0, tp_q}) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.capture_done_clr && !bus.run) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: ;
        endcase

        if (start) begin
            state_d = PRE;
            waddr_d = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            tp_d    = bus.trig_pos;
        end

        // Abort keeps the last trigger address and whatever completion flag was already set.
        if (bus.stop) begin
            state_d     = IDLE;
            trig_addr_d = trig_addr_q;
            done_d      = done_q;
        end

        armed_d = (state_d == ARMED);
        busy_d  = (state_d inside {PRE, ARMED, POST});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            waddr_q     <= '0;
            trig_addr_q <= '0;
            tp_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            trig_addr_q <= trig_addr_d;
            tp_q        <= tp_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.armed        = armed_q;
    assign bus.we           = wr;
    assign bus.waddr        = waddr_q;
    assign bus.trig_addr    = trig_addr_q;
    assign bus.capture_done = done_q;
    assign bus.busy         = busy_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl at ADDR_W=4: directed scenarios then random traffic, all outputs
// compared every cycle against a write-budget model of one acquisition.
module tb_capture_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    localparam int P_IDLE  = 0;
    localparam int P_PRE   = 1;
    localparam int P_ARMED = 2;
    localparam int P_POST  = 3;
    localparam int P_DONE  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    capture_ctrl_if #(.ADDR_W(AW)) bus ();

    capture_ctrl #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_dut_wr = 0;

    // Model: phase, write pointer, writes still owed before the next phase change.
    int m_phase;
    int m_wptr;
    int m_left;
    int m_tp;
    int m_taddr;
    bit m_done;

    logic [AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_wptr  = 0;
        m_left  = 0;
        m_tp    = 0;
        m_taddr = 0;
        m_done  = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_start();
        m_phase = P_PRE;
        m_wptr  = 0;
        m_done  = 1'b0;
        m_tp    = int'(bus.trig_pos);
        m_left  = DEPTH - m_tp;
    endtask

    task automatic model_step();
        bit busy_m, wr, hit;
        busy_m = (m_phase == P_PRE) || (m_phase == P_ARMED) || (m_phase == P_POST);
        wr     = bus.smpl_en && busy_m;
        hit    = (bus.trig_in & bus.trig_en) != 0;
        if (wr) m_wptr = (m_wptr + 1) % DEPTH;
        if (bus.stop) begin
            m_phase = P_IDLE;
            return;
        end
        case (m_phase)
            P_IDLE: if (bus.run) model_start();
            P_PRE: begin
                if (wr) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_ARMED;
                end
            end
            P_ARMED: begin
                if (hit) begin
                    m_taddr = m_wptr;
                    if (m_tp == 0) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                    end else begin
                        m_phase = P_POST;
                        m_left  = m_tp;
                    end
                end
            end
            P_POST: begin
                if (wr) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_DONE;
                        m_done  = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.run) model_start();
                else if (bus.capture_done_clr) begin
                    m_phase = P_IDLE;
                    m_done  = 1'b0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        bit busy_m, we_m;
        busy_m = (m_phase == P_PRE) || (m_phase == P_ARMED) || (m_phase == P_POST);
        we_m   = bus.smpl_en && busy_m;
        chk("busy", bus.busy, busy_m);
        chk("armed", bus.armed, m_phase == P_ARMED);
        chk("we", bus.we, we_m);
        chk("waddr", bus.waddr, m_wptr);
        chk("trig_addr", bus.trig_addr, m_taddr);
        chk("capture_done", bus.capture_done, m_done);
        if (we_m) exp_q.push_back(AW'(m_wptr));
        if (bus.we === 1'b1) begin
            n_dut_wr++;
            if (exp_q.size() == 0) chk("sb_extra_write", bus.we, 1'b0);
            else chk("sb_write_addr", bus.waddr, exp_q.pop_front());
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the following negedge.
    task automatic cycle();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus.run = 0; bus.stop = 0; bus.smpl_en = 0; bus.trig_pos = '0;
        bus.trig_in = '0; bus.trig_en = '0; bus.capture_done_clr = 0;
        model_reset();

        // Reset state
        @(negedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1;

        // Normal capture, trig_pos=4
        bus.trig_pos = 4; bus.smpl_en = 1; bus.trig_en = 5'b00001;
        bus.run = 1; cycle(); bus.run = 0;
        repeat (11) cycle();
        chk("not_armed_after_11", bus.armed, 1'b0);
        cycle();
        chk("armed_after_12", bus.armed, 1'b1);
        chk("waddr_at_arm", bus.waddr, 12);
        for (int i = 0; i < 40 && m_wptr != 7; i++) cycle();
        chk("waddr_before_hit", bus.waddr, 7);
        bus.trig_in = 5'b00001; cycle(); bus.trig_in = '0;
        chk("trig_addr_normal", bus.trig_addr, 8);
        chk("armed_drop", bus.armed, 1'b0);
        repeat (3) cycle();
        chk("done_before_last_post", bus.capture_done, 1'b0);
        cycle();
        chk("done_after_4_post", bus.capture_done, 1'b1);
        chk("no_write_in_done", bus.we, 1'b0);
        chk("waddr_after_post", bus.waddr, 12);
        repeat (3) cycle();
        bus.capture_done_clr = 1; cycle(); bus.capture_done_clr = 0;
        chk("clr_done", bus.capture_done, 1'b0);
        chk("clr_idle", bus.busy, 1'b0);

        // Early trigger ignored in PRE, masked channel, then unmasked
        bus.trig_pos = 4; bus.trig_en = 5'b00001; bus.trig_in = 5'b00001;
        bus.run = 1; cycle(); bus.run = 0;
        repeat (6) cycle();
        bus.trig_in = 5'b00010;
        repeat (6) cycle();
        chk("armed_despite_pre_trig", bus.armed, 1'b1);
        repeat (3) cycle();
        chk("masked_no_trigger", bus.armed, 1'b1);
        bus.trig_en = 5'b00010; cycle();
        bus.trig_in = '0; bus.trig_en = 5'b00001;
        chk("unmasked_trigger", bus.armed, 1'b0);
        chk("trig_addr_wrap", bus.trig_addr, 0);
        repeat (2) cycle();
        bus.stop = 1; cycle(); bus.stop = 0;
        chk("stop_post_busy", bus.busy, 1'b0);
        chk("stop_post_done", bus.capture_done, 1'b0);
        chk("stop_keeps_trig_addr", bus.trig_addr, 0);
        bus.run = 1; bus.stop = 1; cycle(); bus.run = 0; bus.stop = 0;
        chk("run_stop_idle", bus.busy, 1'b0);
        cycle();

        // trig_pos=0, sample every third cycle
        bus.trig_pos = 0; bus.smpl_en = 0;
        bus.run = 1; cycle(); bus.run = 0;
        n_dut_wr = 0;
        for (int i = 0; i < 200 && bus.armed !== 1'b1; i++) begin
            bus.smpl_en = (i % 3 == 0);
            cycle();
        end
        chk("tp0_writes_to_arm", n_dut_wr, 16);
        chk("tp0_armed", bus.armed, 1'b1);
        chk("tp0_waddr_wrapped", bus.waddr, 0);
        bus.smpl_en = 0;
        repeat (2) cycle();
        bus.smpl_en = 1; bus.trig_in = 5'b00001; cycle(); bus.trig_in = '0;
        chk("tp0_done", bus.capture_done, 1'b1);
        chk("tp0_trig_addr", bus.trig_addr, 1);
        repeat (3) cycle();
        chk("tp0_no_post_writes", bus.waddr, 1);

        // Restart straight from DONE (run together with clr: run wins)
        bus.trig_pos = 3; bus.run = 1; bus.capture_done_clr = 1; cycle();
        bus.run = 0; bus.capture_done_clr = 0;
        chk("restart_waddr", bus.waddr, 0);
        chk("restart_done", bus.capture_done, 1'b0);
        chk("restart_busy", bus.busy, 1'b1);
        repeat (13) cycle();
        chk("restart_armed", bus.armed, 1'b1);
        bus.trig_in = 5'b00001; cycle(); bus.trig_in = '0;
        cycle();

        // Asynchronous reset in POST
        #2 rst_n = 0;
        #1;
        chk("rst_armed", bus.armed, 1'b0);
        chk("rst_we", bus.we, 1'b0);
        chk("rst_waddr", bus.waddr, 0);
        chk("rst_trig_addr", bus.trig_addr, 0);
        chk("rst_done", bus.capture_done, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bus.trig_pos = 2; bus.run = 1; cycle(); bus.run = 0;
        repeat (14) cycle();
        chk("post_rst_armed", bus.armed, 1'b1);
        bus.trig_in = 5'b00001; cycle(); bus.trig_in = '0;
        repeat (2) cycle();
        chk("post_rst_done", bus.capture_done, 1'b1);
        bus.capture_done_clr = 1; cycle(); bus.capture_done_clr = 0;

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.trig_pos         = AW'($urandom_range(0, DEPTH - 1));
            bus.run              = ($urandom_range(0, 19) == 0);
            bus.stop             = ($urandom_range(0, 79) == 0);
            bus.smpl_en          = $urandom_range(0, 1);
            bus.trig_in          = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'b0;
            bus.trig_en          = 5'($urandom_range(0, 31));
            bus.capture_done_clr = ($urandom_range(0, 29) == 0);
            cycle();
        end
        bus.run = 0; bus.stop = 0; bus.capture_done_clr = 0; bus.trig_in = '0;
        cycle();

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
